// File: rtl/pmod_jtag_pkg.sv
// pmod_jtag_pkg: shared types, synchronizer bit map and status word layout for the ER2 command path
package pmod_jtag_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_UPD, COMMIT} state_t;
    localparam int DEF_DR_W  = 16;
    localparam int SIG_TCK   = 0;
    localparam int SIG_TDI   = 1;
    localparam int SIG_TLR   = 2;
    localparam int SIG_EN    = 3;
    localparam int SIG_SDC   = 4;
    localparam int SIG_UPD   = 5;
    localparam int SIG_N     = 6;
    localparam int ST_VALID  = 15;
    localparam int ST_OVF_HI = 14;
    localparam int ST_OVF_LO = 8;
    localparam int ST_FRM_HI = 7;
    localparam int ST_FRM_LO = 0;
    function automatic logic [DEF_DR_W-1:0] status_word(input logic valid, input logic [6:0] ovf, input logic [7:0] frm);
        return {valid, ovf, frm};
    endfunction
endpackage

// File: rtl/jtag_sig_sync.sv
// jtag_sig_sync: multi-stage synchronizer with one-clock rise/fall pulses per bit
module jtag_sig_sync #(
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] q_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            q_d <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            q_d <= sync_q[STAGES-1];
        end
    end
    assign q    = sync_q[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;
endmodule

// File: rtl/jtag_er2_cmd_rx.sv
// jtag_er2_cmd_rx: oversampled GW_JTAG ER2 DR receiver presenting commands on a valid/ready port
module jtag_er2_cmd_rx
    import pmod_jtag_pkg::*;
#(
    parameter int DR_W        = DEF_DR_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tck_i,
    input  logic             tdi_i,
    input  logic             test_logic_reset_i,
    input  logic             enable_er2_i,
    input  logic             shift_dr_capture_dr_i,
    input  logic             update_dr_i,
    output logic             tdo_er2_o,
    input  logic [DR_W-1:0]  status_i,
    output logic [DR_W-1:0]  cmd_data_o,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [CNT_W-1:0] ovf_cnt_o,
    output logic [CNT_W-1:0] frm_err_cnt_o
);
    localparam int BC_W = $clog2(DR_W + 2);
    logic [SIG_N-1:0] s_q, s_rise, s_fall;
    logic             sync_unused;
    logic             tck_rise, tck_fall, tdi, tlr, en, en_fall, act, upd_rise;
    state_t           state, state_nx;
    logic [DR_W-1:0]  sr, sr_nx;
    logic [BC_W-1:0]  bit_cnt, cnt_nx;
    logic             commit_ok, commit_err, free;
    jtag_sig_sync #(.W(SIG_N), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .d    ({update_dr_i, shift_dr_capture_dr_i, enable_er2_i, test_logic_reset_i, tdi_i, tck_i}),
        .q    (s_q),
        .rise (s_rise),
        .fall (s_fall)
    );
    assign tck_rise    = s_rise[SIG_TCK];
    assign tck_fall    = s_fall[SIG_TCK];
    assign tdi         = s_q[SIG_TDI];
    assign tlr         = s_q[SIG_TLR];
    assign en          = s_q[SIG_EN];
    assign en_fall     = s_fall[SIG_EN];
    assign act         = en & s_q[SIG_SDC];
    assign upd_rise    = s_rise[SIG_UPD];
    assign sync_unused = ^{s_q[SIG_TCK], s_q[SIG_UPD], s_rise[SIG_TDI], s_rise[SIG_TLR], s_rise[SIG_EN], s_rise[SIG_SDC],
                           s_fall[SIG_TDI], s_fall[SIG_TLR], s_fall[SIG_SDC], s_fall[SIG_UPD]};
    assign free        = ~cmd_valid_o | cmd_ready_i;
    always_comb begin
        state_nx   = state;
        sr_nx      = sr;
        cnt_nx     = bit_cnt;
        commit_ok  = 1'b0;
        commit_err = 1'b0;
        case (state)
            IDLE: if (act && tck_rise) begin
                sr_nx    = status_i;
                cnt_nx   = '0;
                state_nx = SHIFT;
            end
            SHIFT: if (act && tck_rise) begin
                sr_nx  = {tdi, sr[DR_W-1:1]};
                cnt_nx = (bit_cnt == BC_W'(DR_W + 1)) ? bit_cnt : bit_cnt + 1'b1;
            end else if (!act) state_nx = WAIT_UPD;
            WAIT_UPD: if (upd_rise && en) state_nx = COMMIT;
            else if (act && tck_rise) begin
                sr_nx    = status_i;
                cnt_nx   = '0;
                state_nx = SHIFT;
            end
            COMMIT: begin
                commit_ok  = bit_cnt == BC_W'(DR_W);
                commit_err = ~commit_ok;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // A TAP reset or losing ER2 abandons the scan but leaves the command port alone
        if (tlr || en_fall) begin
            state_nx   = IDLE;
            sr_nx      = '0;
            cnt_nx     = '0;
            commit_ok  = 1'b0;
            commit_err = 1'b0;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            tdo_er2_o     <= 1'b0;
            cmd_data_o    <= '0;
            cmd_valid_o   <= 1'b0;
            ovf_cnt_o     <= '0;
            frm_err_cnt_o <= '0;
        end else begin
            state   <= state_nx;
            sr      <= sr_nx;
            bit_cnt <= cnt_nx;
            if (state == SHIFT && tck_fall) tdo_er2_o <= sr[0];
            if (commit_ok && free) begin
                cmd_data_o  <= sr;
                cmd_valid_o <= 1'b1;
            end else if (cmd_valid_o && cmd_ready_i) cmd_valid_o <= 1'b0;
            if (commit_ok && !free && ovf_cnt_o != '1) ovf_cnt_o <= ovf_cnt_o + 1'b1;
            if (commit_err && frm_err_cnt_o != '1) frm_err_cnt_o <= frm_err_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_jtag_er2_cmd_rx.sv
// tb_jtag_er2_cmd_rx: directed ER2 scans with a scoreboard monitor on the command port
module tb_jtag_er2_cmd_rx;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        tck_i = 1'b0, tdi_i = 1'b0, tlr_i = 1'b0, en_i = 1'b0, sdc_i = 1'b0, upd_i = 1'b0;
    logic        tdo_er2_o;
    logic [15:0] status_i = '0;
    logic [15:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b1;
    logic [7:0]  ovf_cnt_o, frm_err_cnt_o;
    int          tests = 0, fails = 0, half = 2;
    logic [15:0] exp_q[$];
    logic        last_hold = 1'b0;
    logic [15:0] last_data = '0;
    always #5 clk = ~clk;
    jtag_er2_cmd_rx #(.DR_W(16), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .tck_i                 (tck_i),
        .tdi_i                 (tdi_i),
        .test_logic_reset_i    (tlr_i),
        .enable_er2_i          (en_i),
        .shift_dr_capture_dr_i (sdc_i),
        .update_dr_i           (upd_i),
        .tdo_er2_o             (tdo_er2_o),
        .status_i              (status_i),
        .cmd_data_o            (cmd_data_o),
        .cmd_valid_o           (cmd_valid_o),
        .cmd_ready_i           (cmd_ready_i),
        .ovf_cnt_o             (ovf_cnt_o),
        .frm_err_cnt_o         (frm_err_cnt_o)
    );
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (half=%0d)", name, got, exp, half);
        end
    endtask
    always @(negedge clk) begin
        if (last_hold && !rst_i) chk("hold_stable", cmd_data_o, last_data);
        if (cmd_valid_o && cmd_ready_i && !rst_i) begin
            if (exp_q.size() == 0) chk("unexpected_cmd", cmd_data_o, 32'hxxxx_xxxx);
            else chk("cmd_data", cmd_data_o, exp_q.pop_front());
        end
        last_hold = cmd_valid_o & ~cmd_ready_i & ~rst_i;
        last_data = cmd_data_o;
    end
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic tck_cycle(input logic b, output logic t);
        tdi_i = b;
        tck_i = 1'b1;
        wclk(half);
        t = tdo_er2_o;
        tck_i = 1'b0;
        wclk(half);
    endtask
    task automatic shift(input logic [31:0] data, input int n, input logic [15:0] st, input bit chk_tdo);
        logic t;
        logic [15:0] cap;
        cap = '0;
        status_i = st;
        en_i = 1'b1;
        sdc_i = 1'b1;
        wclk(half);
        tck_cycle(1'b0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle(data[i], t);
            if (i < 16) cap[i] = t;
        end
        sdc_i = 1'b0;
        wclk(half);
        if (chk_tdo) chk("tdo_status", {16'h0, cap}, {16'h0, st});
    endtask
    task automatic update();
        upd_i = 1'b1;
        wclk(2 * half);
        upd_i = 1'b0;
        wclk(8);
    endtask
    task automatic scan(input logic [15:0] d, input logic [15:0] st, input bit chk_tdo, input bit push);
        if (push) exp_q.push_back(d);
        shift({16'h0, d}, 16, st, chk_tdo);
        update();
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            wclk(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask
    task automatic do_reset();
        {tck_i, tdi_i, tlr_i, en_i, sdc_i, upd_i} = '0;
        rst_i = 1'b1;
        wclk(3);
        rst_i = 1'b0;
        wclk(1);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int s = 0; s < 2; s++) begin
            half = s ? 8 : 2;
            exp_q.delete();
            do_reset();
            chk("rst_tdo", tdo_er2_o, 0);
            chk("rst_data", cmd_data_o, 0);
            chk("rst_valid", cmd_valid_o, 0);
            chk("rst_ovf", ovf_cnt_o, 0);
            chk("rst_frm", frm_err_cnt_o, 0);
            cmd_ready_i = 1'b1;
            scan(16'hA55A, 16'h0000, 0, 1);
            drain();
            chk("t1_ovf", ovf_cnt_o, 0);
            chk("t1_frm", frm_err_cnt_o, 0);
            scan(16'h0F0F, 16'h1234, 1, 1);
            drain();
            shift(32'h7FFF, 15, 16'h0, 0);
            update();
            chk("t3_frm15", frm_err_cnt_o, 1);
            chk("t3_valid", cmd_valid_o, 0);
            shift(32'h1FFFF, 17, 16'h0, 0);
            update();
            chk("t3_frm17", frm_err_cnt_o, 2);
            cmd_ready_i = 1'b0;
            scan(16'h0001, 16'h0, 0, 1);
            scan(16'h0002, 16'h0, 0, 0);
            chk("t4_ovf", ovf_cnt_o, 1);
            chk("t4_data", cmd_data_o, 16'h0001);
            chk("t4_valid", cmd_valid_o, 1);
            cmd_ready_i = 1'b1;
            drain();
            wclk(1);
            chk("t4_valid_clr", cmd_valid_o, 0);
            shift(32'hFF, 8, 16'h0, 0);
            tlr_i = 1'b1;
            wclk(4);
            tlr_i = 1'b0;
            wclk(4);
            update();
            chk("t5_frm_tlr", frm_err_cnt_o, 2);
            scan(16'h00FF, 16'h0, 0, 1);
            drain();
            chk("t5_frm", frm_err_cnt_o, 2);
            chk("t5_ovf", ovf_cnt_o, 1);
            cmd_ready_i = 1'b0;
            scan(16'h1111, 16'h0, 0, 0);
            chk("t6_valid", cmd_valid_o, 1);
            chk("t6_data", cmd_data_o, 16'h1111);
            shift(32'h3, 5, 16'h0, 0);
            rst_i = 1'b1;
            wclk(1);
            chk("t6_rst_valid", cmd_valid_o, 0);
            chk("t6_rst_data", cmd_data_o, 0);
            chk("t6_rst_tdo", tdo_er2_o, 0);
            chk("t6_rst_ovf", ovf_cnt_o, 0);
            chk("t6_rst_frm", frm_err_cnt_o, 0);
            rst_i = 1'b0;
            wclk(1);
            update();
            cmd_ready_i = 1'b1;
            scan(16'hBEEF, 16'h0, 0, 1);
            drain();
            chk("t6_frm", frm_err_cnt_o, 0);
            chk("t6_ovf", ovf_cnt_o, 0);
        end
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
